mips_cpu_reg_wb_arbiter: RTL



---
 rtl/mips_cpu_reg_wb_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/mips_cpu_reg_wb_arbiter.sv
// Writeback arbiter for the register file's single write port (ALU/link vs. load path),
// plus a load scoreboard that stalls decode while a source register has a load in flight.
module mips_cpu_reg_wb_arbiter #(
    parameter int         NREGS    = 32,
    parameter logic [4:0] ZERO_REG = 5'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        ld_valid,
    input  logic [4:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        ld_issue,
    input  logic [4:0]  ld_issue_addr,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    output logic        hazard_stall,
    output logic        rf_write_en,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_writedata
);

    typedef enum logic {GRANT_ALU = 1'b0, GRANT_LD = 1'b1} grant_e;

    grant_e           last_grant_q, last_grant_d;
    logic [NREGS-1:0] pending_q, pending_d;
    logic             rf_write_en_q, rf_write_en_d;
    logic [4:0]       rf_a3_q, rf_a3_d;
    logic [31:0]      rf_writedata_q, rf_writedata_d;
    logic             alu_xfer;
    logic             ld_xfer;
    logic             wb_hit;

    // Handshake: a source raises valid with addr/data and holds all three until it sees ready;
    // a transfer happens on the cycle valid && ready. ready is combinational, never high in
    // reset, and at most one source is ready per cycle (round-robin on contention).
    always_comb begin
        alu_ready = 1'b0;
        ld_ready  = 1'b0;
        if (!reset) begin
            if (alu_valid && ld_valid) begin
                alu_ready = (last_grant_q == GRANT_LD);
                ld_ready  = (last_grant_q == GRANT_ALU);
            end else begin
                alu_ready = alu_valid;
                ld_ready  = ld_valid;
            end
        end
    end

    assign alu_xfer = alu_valid && alu_ready;
    assign ld_xfer  = ld_valid && ld_ready;

    always_comb begin
        last_grant_d   = last_grant_q;
        rf_write_en_d  = 1'b0;
        rf_a3_d        = rf_a3_q;
        rf_writedata_d = rf_writedata_q;
        pending_d      = pending_q;

        if (alu_xfer) begin
            last_grant_d   = GRANT_ALU;
            rf_write_en_d  = (alu_addr != ZERO_REG);
            rf_a3_d        = alu_addr;
            rf_writedata_d = alu_data;
        end else if (ld_xfer) begin
            last_grant_d   = GRANT_LD;
            rf_write_en_d  = (ld_addr != ZERO_REG);
            rf_a3_d        = ld_addr;
            rf_writedata_d = ld_data;
        end

        // The set is applied after the clear: a re-issue to the same register stays outstanding.
        if (ld_xfer) begin
            pending_d[ld_addr] = 1'b0;
        end
        if (ld_issue && (ld_issue_addr != ZERO_REG)) begin
            pending_d[ld_issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q   <= GRANT_LD;
            pending_q      <= '0;
            rf_write_en_q  <= 1'b0;
            rf_a3_q        <= 5'd0;
            rf_writedata_q <= 32'd0;
        end else begin
            last_grant_q   <= last_grant_d;
            pending_q      <= pending_d;
            rf_write_en_q  <= rf_write_en_d;
            rf_a3_q        <= rf_a3_d;
            rf_writedata_q <= rf_writedata_d;
        end
    end

    // A write registered this cycle has not reached the file yet, so it still counts as a hazard.
    assign wb_hit = rf_write_en_q && (rf_a3_q != ZERO_REG) &&
                    ((rf_a3_q == rs_addr) || (rf_a3_q == rt_addr));

    assign hazard_stall = pending_q[rs_addr] || pending_q[rt_addr] || wb_hit;

    assign rf_write_en  = rf_write_en_q;
    assign rf_a3        = rf_a3_q;
    assign rf_writedata = rf_writedata_q;

endmodule
